tt_um_serial_add_seq: RTL
=========================

TT_UM_SERIAL_ADD_SEQ -- requirements
Module: tt_um_serial_add_seq

Interface
REQ-001 Parameter NBITS, default 8, is the operand width; legal values are 2..8 and the SHALL apply to all width rules below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  design enable; when low, all state SHALL hold.
REQ-005 ui_in  input  8  operand data byte; only bits [NBITS-1:0] SHALL be used.
REQ-006 uio_in  input  8  control: [0] start, [1] sel (0=A, 1=B), [2] load; bits [7:3] SHALL be ignored.
REQ-007 uo_out  output  8  result register: sum[NBITS-1:0], with upper bits 0.
REQ-008 uio_out  output  8  status: [7] carry_out, [6] busy, [5] done; bits [4:0] SHALL be driven 0.
REQ-009 uio_oe  output  8  SHALL be constant 8'b1110_0000.

Function
REQ-010 The block SHALL sequence one half-adder pair per cycle as a bit-serial adder: s = a^b^c and c' = (a&b)|(c&(a^b)), LSB first.
REQ-011 FSM states SHALL be IDLE, RUN and DONE; all transitions SHALL occur only on cycles where ena=1.
REQ-012 Load handling: in IDLE or DONE, load=1 with start=0 SHALL capture ui_in[NBITS-1:0] into A (sel=0) or B (sel=1) at the next edge.
REQ-013 Load with start=1 in the same cycle: start SHALL win, and the load SHALL be ignored.
REQ-014 Start from IDLE or DONE: the next edge SHALL enter RUN, clear bit counter, carry and done, and copy A and B into working shift registers.
REQ-015 RUN SHALL last exactly NBITS cycles, with busy=1 in every one.
  - Each edge processes one bit and shifts the sum bit into the sum shift register.
  - The counter increments on each edge.
REQ-016 On the edge processing bit NBITS-1, the FSM SHALL go to DONE in the same edge.
  - uo_out and carry_out load the completed sum and final carry.
  - done is set.
REQ-017 Latency: done SHALL be first visible NBITS edges after the edge that sampled start (8 for NBITS=8).
REQ-018 uo_out and carry_out SHALL change only at RUN completion or reset; intermediate partial sums SHALL never appear on uo_out.
REQ-019 done SHALL remain 1 in DONE until the next accepted start or reset; busy and done SHALL never both be 1.
REQ-020 In RUN, start and load SHALL be ignored; the A and B registers SHALL stay unchanged.
REQ-021 Overflow SHALL wrap modulo 2^NBITS, and carry_out SHALL hold the bit-NBITS carry.
REQ-022 With ena=0 in RUN, the counter, carry and shift registers SHALL freeze, and the run resumes bit-exact when ena returns to 1.
REQ-023 A and B SHALL persist across runs, so a repeated start re-adds the same operands.

Reset
REQ-024 With rst_n=0 at a clock edge, the next state SHALL be IDLE regardless of ena.
  - A, B, shift registers, counter and carry become 0.
  - uo_out = 0x00, uio_out = 0x00.
REQ-025 Reset asserted mid-RUN SHALL abort the run and leave uo_out=0 with done=0.
REQ-026 uio_oe SHALL be 8'b1110_0000 during and after reset.

Verification
REQ-027 Load A=0x5A, B=0x3C, pulse start -> busy=1 for 8 cycles; then uo_out=0x96, carry=0, done=1.
REQ-028 A=0xFF, B=0x01, start -> uo_out=0x00, carry=1; then A=0xFF, B=0xFF, start -> uo_out=0xFE, carry=1.
REQ-029 Start at RUN cycle 3, plus load A=0x00 at cycle 5 -> both ignored; done after the original 8 cycles; result unchanged (0x96 for operands 0x5A+0x3C).
REQ-030 rst_n=0 during RUN cycle 4 -> next cycle: IDLE, uo_out=0x00, uio_out=0x00; a subsequent start without load gives 0x00, carry=0.
REQ-031 ena=0 for 5 cycles mid-RUN (A=0x5A, B=0x3C) -> busy holds 1; done is delayed by exactly 5 cycles; result 0x96.
REQ-032 Load and start in the same cycle in DONE -> operand unchanged; rerun result equals the previous result; done drops for 8 cycles and then reasserts.

Source files
------------

// File: rtl/tt_um_serial_add_seq.sv
// Bit-serial adder sequencer: operands A/B are loaded bytewise, then summed one bit per
// enabled clock, LSB first. The result register updates only when the whole sum is ready.
module tt_um_serial_add_seq #(
  parameter int unsigned NBITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] LastBit = 4'(NBITS - 1);

  logic [1:0]       state;
  logic [NBITS-1:0] op_a, op_b;
  logic [NBITS-1:0] sh_a, sh_b, sum_sh;
  logic [NBITS-1:0] result;
  logic [3:0]       bit_cnt;
  logic             carry, carry_out, done;

  logic start, sel, load;
  logic sum_bit, carry_nxt;
  logic busy;

  assign start = uio_in[0];
  assign sel   = uio_in[1];
  assign load  = uio_in[2];

  assign sum_bit   = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_nxt = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));

  assign busy = (state == StRun);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      op_a      <= '0;
      op_b      <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      sum_sh    <= '0;
      result    <= '0;
      bit_cnt   <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else if (ena) begin
      case (state)
        StIdle, StDone: begin
          // A simultaneous load is dropped when start is present.
          if (start) begin
            state   <= StRun;
            bit_cnt <= '0;
            carry   <= 1'b0;
            done    <= 1'b0;
            sh_a    <= op_a;
            sh_b    <= op_b;
          end else if (load) begin
            if (sel) op_b <= ui_in[NBITS-1:0];
            else     op_a <= ui_in[NBITS-1:0];
          end
        end
        StRun: begin
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          carry   <= carry_nxt;
          sum_sh  <= {sum_bit, sum_sh[NBITS-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == LastBit) begin
            state     <= StDone;
            result    <= {sum_bit, sum_sh[NBITS-1:1]};
            carry_out <= carry_nxt;
            done      <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    uo_out              = 8'h00;
    uo_out[NBITS-1:0]   = result;
  end

  assign uio_out = {carry_out, busy, done, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

  logic unused_inputs;
  assign unused_inputs = ^{uio_in[7:3], ui_in};

endmodule
